// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use stalls, taken-branch flushes,
// operand forwarding selects and saturating stall/flush event counters.
module ex_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned SL_W = 4;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [SL_W-1:0] stall_left, stall_left_nxt;
  logic            stall_inc, flush_inc;
  logic            br_taken, luh;
  logic            pc_write_raw, ifid_write_raw, ifid_flush_raw, idex_bubble_raw, pc_sel_raw;
  logic [1:0]      fwd_a_raw, fwd_b_raw;

  assign br_taken = ex_branch & ex_zero;
  assign luh      = id_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // Next-state, counter events and ungated control outputs
  always_comb begin
    state_nxt       = state;
    stall_left_nxt  = stall_left;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    pc_write_raw    = 1'b1;
    ifid_write_raw  = 1'b1;
    ifid_flush_raw  = 1'b0;
    idex_bubble_raw = 1'b0;
    pc_sel_raw      = 1'b0;
    case (state)
      RUN: begin
        if (br_taken) begin
          pc_sel_raw      = 1'b1;
          ifid_flush_raw  = 1'b1;
          idex_bubble_raw = 1'b1;
          flush_inc       = 1'b1;
          state_nxt       = FLUSH;
        end else if (luh) begin
          pc_write_raw    = 1'b0;
          ifid_write_raw  = 1'b0;
          idex_bubble_raw = 1'b1;
          stall_inc       = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt      = STALL;
            stall_left_nxt = SL_W'(LOAD_LAT - 1);
          end
        end
      end
      STALL: begin
        pc_write_raw    = 1'b0;
        ifid_write_raw  = 1'b0;
        idex_bubble_raw = 1'b1;
        stall_inc       = 1'b1;
        stall_left_nxt  = stall_left - SL_W'(1);
        if (stall_left <= SL_W'(1)) state_nxt = RUN;
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // MEM result is newer than WB, so it wins
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1))   fwd_a_raw = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) fwd_a_raw = 2'b01;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2))   fwd_b_raw = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) fwd_b_raw = 2'b01;
  end

  // Hold the pipeline frozen and bubbled while reset is asserted
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    pc_sel      = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (reset) begin
      pc_write    = pc_write_raw;
      ifid_write  = ifid_write_raw;
      ifid_flush  = ifid_flush_raw;
      idex_bubble = idex_bubble_raw;
      pc_sel      = pc_sel_raw;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      stall_left <= '0;
    end else begin
      state      <= state_nxt;
      stall_left <= stall_left_nxt;
    end
  end

  // Event counters saturate at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline's execute stage. It detects load-use hazards between ID and EX and stalls the front end for the configured load latency. It resolves taken branches from the EX Branch and Zero signals by redirecting the PC and squashing younger instructions. It also drives the forwarding selects for both ALU operands and keeps saturating stall and flush event counters.

## Interface
Parameters:
- LOAD_LAT, 1: data-memory load latency in cycles (legal range 1..8); a load-use hazard stalls for exactly LOAD_LAT cycles.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_regwrite, ex_memread  in  1  EX instruction writes the register file / is a load.
- ex_branch, ex_zero  in  1  EX instruction is a branch / ALU Zero flag.
- mem_rd, wb_rd  in  5  destination registers in MEM and WB.
- mem_regwrite, wb_regwrite  in  1  MEM and WB write enables.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_bubble  out  1  load a bubble into ID/EX (clears control bits).
- pc_sel  out  1  1 selects the branch target PC+(imm<<1); 0 selects PC+4.
- fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 10 MEM result, 01 WB result.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total taken-branch flushes, saturating.

## Operation
- FSM states: RUN, STALL, FLUSH. The state is registered. Control outputs are combinational from the state and the current inputs.
- Taken-branch condition: br_taken = ex_branch & ex_zero.
- Load-use hazard: luh = id_valid & ex_memread & ex_regwrite & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_sel=0.
- RUN:
  - If br_taken: pc_sel=1, ifid_flush=1, idex_bubble=1. flush_cnt increments. Next state is FLUSH.
  - Else if luh: pc_write=0, ifid_write=0, idex_bubble=1. stall_cnt increments. If LOAD_LAT>1, next state is STALL and stall_left is loaded with LOAD_LAT-1. Otherwise the state stays RUN.
- Priority: br_taken wins over luh when both are true in the same cycle.
- STALL:
  - Stall outputs (pc_write=0, ifid_write=0, idex_bubble=1) are asserted every cycle; stall_cnt increments every cycle.
  - stall_left decrements each cycle. When stall_left==1, next state is RUN.
  - ex_branch, ex_zero and luh are ignored (EX holds a bubble).
- FLUSH:
  - Lasts exactly one cycle with default outputs.
  - luh and br_taken are masked because ID and EX hold bubbles.
  - Next state is RUN.
- Forwarding (combinational, independent of FSM state), shown for fwd_a; fwd_b is identical with ex_rs2:
  - 10 if mem_regwrite & mem_rd != 0 & mem_rd == ex_rs1.
  - Else 01 if wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1.
  - Else 00.
  - MEM has priority over WB.
- Counters hold at 2^CNT_W-1 instead of wrapping.

## Timing
- Load-use stall: total stall cycles = LOAD_LAT, counting the detection cycle. The dependent instruction leaves ID on the edge after the last stall cycle.
- Branch: redirect and squash take effect on the edge that ends the br_taken cycle. The branch penalty is 2 cycles: the squashed IF/ID and ID/EX instructions.
- Forwarding has zero latency: selects are valid in the same cycle as the inputs.
- While reset is low:
  - state=RUN, stall_left=0, stall_cnt=0, flush_cnt=0.
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pc_sel=0, fwd_a=fwd_b=00.
- Reset deassertion is synchronous to clk. The first edge after release evaluates in RUN.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately. There is no residual stall after release.

## Test plan
- Load-use on rs1, LOAD_LAT=1:
  - Stimulus: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs1=5, id_valid=1.
  - Response: pc_write=0 and idex_bubble=1 for exactly 1 cycle; stall_cnt=1; state stays RUN.
- LOAD_LAT=3, rs2 hazard:
  - Stimulus: hazard on id_rs2 with id_uses_rs2=1.
  - Response: stall outputs held for 3 consecutive cycles, then released; stall_cnt=3.
  - Stimulus: same hazard with id_uses_rs2=0.
  - Response: no stall.
- Taken branch:
  - Stimulus: ex_branch=1, ex_zero=1.
  - Response: pc_sel=1, ifid_flush=1, idex_bubble=1 for one cycle; next cycle FLUSH with default outputs; flush_cnt=1.
  - Stimulus: ex_zero=0.
  - Response: no action.
- Simultaneous br_taken and luh in RUN:
  - Response: the flush response only; stall_cnt unchanged.
- Forwarding with mem_rd=wb_rd=ex_rs1=7 and both write enables set:
  - Response: fwd_a=10.
  - Stimulus: mem_rd=7 with mem_regwrite=0.
  - Response: fwd_a=01.
  - Stimulus: rd=0 in every stage.
  - Response: fwd_a=00.
- Reset low during the 2nd cycle of a LOAD_LAT=3 stall:
  - Response: outputs go to reset values immediately; counters read 0 after release; stall outputs not asserted after release.
